// File: rtl/decode_pipe.sv
// Purpose : decode stage; register file with writeback bypass, operand/immediate
//           generation, load-use hazard detection and the ID/EX pipeline register.
// Latency : one cycle from decode inputs to ex_* outputs. Writeback data reaches
//           the operand reads in the same cycle through the bypass.
// Backpressure: hold freezes ID/EX and flush squashes it to a bubble. stall_out
//           asks IF/PC to hold the current instruction for one cycle on a load-use hazard.
// Ports:
//   clk, rst                        clock and asynchronous active-high reset
//   id_valid, instr, pc_next        incoming instruction from the IF/ID register
//   imm_sel, zext, bsrc_imm, rd_sel decode controls for immediate, B operand, destination
//   reg_wr, mem_rd, uses_rs, uses_rt instruction attributes
//   wb_en, wb_reg, wb_data          register file write port from writeback
//   hold, flush                     ID/EX control from downstream
//   stall_out                       combinational load-use stall request
//   ex_*                            registered ID/EX contents
// DATA_W must be at least 11 so that imm11 fits.
module decode_pipe #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int LINK_REG   = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [15:0]           instr,
  input  logic [DATA_W-1:0]     pc_next,
  input  logic [1:0]            imm_sel,
  input  logic                  zext,
  input  logic                  bsrc_imm,
  input  logic [1:0]            rd_sel,
  input  logic                  reg_wr,
  input  logic                  mem_rd,
  input  logic                  uses_rs,
  input  logic                  uses_rt,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  hold,
  input  logic                  flush,
  output logic                  stall_out,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_a,
  output logic [DATA_W-1:0]     ex_b,
  output logic [DATA_W-1:0]     ex_rt_data,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [DATA_W-1:0]     ex_pc_next,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_reg_wr,
  output logic                  ex_mem_rd
);

  localparam int NREG = 1 << REG_ADDR_W;

  typedef struct packed {
    logic                  valid;
    logic [DATA_W-1:0]     a;
    logic [DATA_W-1:0]     b;
    logic [DATA_W-1:0]     rt_data;
    logic [DATA_W-1:0]     imm;
    logic [DATA_W-1:0]     pc_next;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_wr;
    logic                  mem_rd;
  } idex_t;

  // Opcode bits above the register fields are decoded upstream.
  logic unused_instr_hi;
  assign unused_instr_hi = ^instr[15:11];

  // Instruction register fields are 3 bits, zero-padded to the file address width.
  logic [REG_ADDR_W-1:0] rs_addr, rt_addr, rd_addr;
  assign rs_addr = REG_ADDR_W'(instr[10:8]);
  assign rt_addr = REG_ADDR_W'(instr[7:5]);

  // Register file
  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];

  always_comb begin
    rf_d = rf_q;
    if (wb_en) rf_d[wb_reg] = wb_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  // Reads see a same-cycle writeback so EX never needs an extra cycle for it.
  logic [DATA_W-1:0] rs_data, rt_data;
  assign rs_data = (wb_en && wb_reg == rs_addr) ? wb_data : rf_q[rs_addr];
  assign rt_data = (wb_en && wb_reg == rt_addr) ? wb_data : rf_q[rt_addr];

  // Immediate generation; size casts of $signed operands sign-extend.
  logic [DATA_W-1:0] imm;
  always_comb begin
    imm = '0;
    case (imm_sel)
      2'd0:    imm = zext ? DATA_W'(instr[4:0]) : DATA_W'($signed(instr[4:0]));
      2'd1:    imm = zext ? DATA_W'(instr[7:0]) : DATA_W'($signed(instr[7:0]));
      2'd2:    imm = DATA_W'($signed(instr[10:0]));
      default: imm = '0;
    endcase
  end

  always_comb begin
    rd_addr = '0;
    case (rd_sel)
      2'd0:    rd_addr = REG_ADDR_W'(instr[4:2]);
      2'd1:    rd_addr = rt_addr;
      2'd2:    rd_addr = rs_addr;
      default: rd_addr = REG_ADDR_W'(LINK_REG);
    endcase
  end

  // ID/EX register
  idex_t ex_q, ex_d;
  logic  hazard;

  // Load-use: the load in EX has not produced data yet. Computed from the
  // current (possibly held) ID/EX contents.
  assign hazard = id_valid & ex_q.valid & ex_q.mem_rd &
                  ((uses_rs & (ex_q.rd == rs_addr)) | (uses_rt & (ex_q.rd == rt_addr)));

  // A flush squashes this instruction anyway, so no stall is requested.
  assign stall_out = hazard & ~flush;

  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (hold) begin
      ex_d = ex_q;
    end else if (hazard) begin
      // Bubble; the bubble clears ex_mem_rd, so the stall lasts one cycle.
      ex_d = '0;
    end else begin
      ex_d.valid   = id_valid;
      ex_d.a       = rs_data;
      ex_d.b       = bsrc_imm ? imm : rt_data;
      ex_d.rt_data = rt_data;
      ex_d.imm     = imm;
      ex_d.pc_next = pc_next;
      ex_d.rd      = rd_addr;
      ex_d.reg_wr  = reg_wr & id_valid;
      ex_d.mem_rd  = mem_rd & id_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  assign ex_valid   = ex_q.valid;
  assign ex_a       = ex_q.a;
  assign ex_b       = ex_q.b;
  assign ex_rt_data = ex_q.rt_data;
  assign ex_imm     = ex_q.imm;
  assign ex_pc_next = ex_q.pc_next;
  assign ex_rd      = ex_q.rd;
  assign ex_reg_wr  = ex_q.reg_wr;
  assign ex_mem_rd  = ex_q.mem_rd;

endmodule

// File: tb/tb_decode_pipe.sv
// Purpose : directed, table-driven checks of decode_pipe (default and 32-bit/16-register builds).
// Latency : checks sample 1 time unit after each rising edge.
// Backpressure: exercises hold, flush and load-use stall sequences by hand.
module tb_decode_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default build
  logic        id_valid, zext, bsrc_imm, reg_wr, mem_rd, uses_rs, uses_rt, wb_en, hold, flush;
  logic [15:0] instr, pc_next, wb_data;
  logic [1:0]  imm_sel, rd_sel;
  logic [2:0]  wb_reg;
  logic        stall_out, ex_valid, ex_reg_wr, ex_mem_rd;
  logic [15:0] ex_a, ex_b, ex_rt_data, ex_imm, ex_pc_next;
  logic [2:0]  ex_rd;

  decode_pipe dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .instr(instr), .pc_next(pc_next),
    .imm_sel(imm_sel), .zext(zext), .bsrc_imm(bsrc_imm), .rd_sel(rd_sel),
    .reg_wr(reg_wr), .mem_rd(mem_rd), .uses_rs(uses_rs), .uses_rt(uses_rt),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .hold(hold), .flush(flush),
    .stall_out(stall_out), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
    .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc_next(ex_pc_next),
    .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr), .ex_mem_rd(ex_mem_rd)
  );

  // Wide build: DATA_W=32, REG_ADDR_W=4, link register r15
  logic        id_valid_w, wb_en_w;
  logic [15:0] instr_w;
  logic [1:0]  imm_sel_w, rd_sel_w;
  logic [3:0]  wb_reg_w;
  logic [31:0] wb_data_w;
  logic        stall_out_w, ex_valid_w, ex_reg_wr_w, ex_mem_rd_w;
  logic [31:0] ex_a_w, ex_b_w, ex_rt_data_w, ex_imm_w, ex_pc_next_w;
  logic [3:0]  ex_rd_w;

  decode_pipe #(.DATA_W(32), .REG_ADDR_W(4), .LINK_REG(15)) dut_w (
    .clk(clk), .rst(rst), .id_valid(id_valid_w), .instr(instr_w), .pc_next(32'h0000_0100),
    .imm_sel(imm_sel_w), .zext(1'b0), .bsrc_imm(1'b0), .rd_sel(rd_sel_w),
    .reg_wr(1'b1), .mem_rd(1'b0), .uses_rs(1'b0), .uses_rt(1'b0),
    .wb_en(wb_en_w), .wb_reg(wb_reg_w), .wb_data(wb_data_w), .hold(1'b0), .flush(1'b0),
    .stall_out(stall_out_w), .ex_valid(ex_valid_w), .ex_a(ex_a_w), .ex_b(ex_b_w),
    .ex_rt_data(ex_rt_data_w), .ex_imm(ex_imm_w), .ex_pc_next(ex_pc_next_w),
    .ex_rd(ex_rd_w), .ex_reg_wr(ex_reg_wr_w), .ex_mem_rd(ex_mem_rd_w)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        id_valid;
    logic [15:0] instr;
    logic [1:0]  imm_sel;
    logic        zext;
    logic        bsrc_imm;
    logic [1:0]  rd_sel;
    logic        reg_wr;
    logic        mem_rd;
    logic [15:0] pc_next;
    logic [15:0] e_a, e_b, e_rt, e_imm;
    logic [2:0]  e_rd;
    logic        e_valid, e_reg_wr, e_mem_rd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // Register file preloaded with r_i = 16'h0011 + 16'h0100*i before these run.
    //            vld instr     sel  z  b  rds wr rd pc        a        b        rt       imm      rd   v  wr rd
    vecs[0] = '{1'b1, 16'h0016, 2'd0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 16'h0010, 16'h0011, 16'hFFF6, 16'h0011, 16'hFFF6, 3'd5, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 16'h0016, 2'd0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 16'h0012, 16'h0011, 16'h0016, 16'h0011, 16'h0016, 3'd5, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 16'h0400, 2'd2, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 16'h0014, 16'h0411, 16'h0011, 16'h0011, 16'hFC00, 3'd4, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 16'h0285, 2'd1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 16'h0016, 16'h0211, 16'hFF85, 16'h0411, 16'hFF85, 3'd4, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 16'h0285, 2'd1, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 16'h0018, 16'h0211, 16'h0085, 16'h0411, 16'h0085, 3'd7, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 16'h07FF, 2'd3, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 16'h001A, 16'h0711, 16'h0711, 16'h0711, 16'h0000, 3'd7, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 16'h010F, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 16'h001C, 16'h0111, 16'h000F, 16'h0011, 16'h000F, 3'd3, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 16'h0016, 2'd0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 16'h001E, 16'h0011, 16'hFFF6, 16'h0011, 16'hFFF6, 3'd5, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    id_valid = 0; instr = '0; pc_next = '0; imm_sel = '0; zext = 0; bsrc_imm = 0;
    rd_sel = '0; reg_wr = 0; mem_rd = 0; uses_rs = 0; uses_rt = 0;
    wb_en = 0; wb_reg = '0; wb_data = '0; hold = 0; flush = 0;
    id_valid_w = 0; wb_en_w = 0; instr_w = '0; imm_sel_w = '0; rd_sel_w = '0;
    wb_reg_w = '0; wb_data_w = '0;

    // Reset and idle
    step(); step();
    chk("rst_ex_valid", ex_valid, 1'b0);
    chk("rst_ex_a", ex_a, 16'h0);
    chk("rst_ex_b", ex_b, 16'h0);
    chk("rst_ex_rt", ex_rt_data, 16'h0);
    chk("rst_ex_imm", ex_imm, 16'h0);
    chk("rst_ex_pc", ex_pc_next, 16'h0);
    chk("rst_ex_rd", ex_rd, 3'd0);
    chk("rst_ex_wr_rd", {ex_reg_wr, ex_mem_rd}, 2'b00);
    chk("rst_stall", stall_out, 1'b0);
    rst = 1'b0;

    id_valid = 1;
    for (int i = 0; i < 8; i++) begin
      instr = 16'(i) << 8;
      step();
      chk($sformatf("rst_r%0d", i), ex_a, 16'h0);
    end

    // Writeback bypass, then the file itself
    wb_en = 1; wb_reg = 3'd3; wb_data = 16'hBEEF; instr = 16'h0300;
    step();
    chk("bypass_rs3", ex_a, 16'hBEEF);
    wb_en = 0;
    step();
    chk("file_rs3", ex_a, 16'hBEEF);

    // Preload r_i = 16'h0011 + 16'h0100*i
    id_valid = 0; wb_en = 1;
    for (int i = 0; i < 8; i++) begin
      wb_reg = 3'(i);
      wb_data = 16'h0011 + 16'(i) * 16'h0100;
      step();
    end
    wb_en = 0;

    // Decode table
    for (int i = 0; i < 8; i++) begin
      id_valid = vecs[i].id_valid; instr = vecs[i].instr; imm_sel = vecs[i].imm_sel;
      zext = vecs[i].zext; bsrc_imm = vecs[i].bsrc_imm; rd_sel = vecs[i].rd_sel;
      reg_wr = vecs[i].reg_wr; mem_rd = vecs[i].mem_rd; pc_next = vecs[i].pc_next;
      step();
      chk($sformatf("v%0d_a", i), ex_a, vecs[i].e_a);
      chk($sformatf("v%0d_b", i), ex_b, vecs[i].e_b);
      chk($sformatf("v%0d_rt", i), ex_rt_data, vecs[i].e_rt);
      chk($sformatf("v%0d_imm", i), ex_imm, vecs[i].e_imm);
      chk($sformatf("v%0d_pc", i), ex_pc_next, vecs[i].pc_next);
      chk($sformatf("v%0d_rd", i), ex_rd, vecs[i].e_rd);
      chk($sformatf("v%0d_valid", i), ex_valid, vecs[i].e_valid);
      chk($sformatf("v%0d_reg_wr", i), ex_reg_wr, vecs[i].e_reg_wr);
      chk($sformatf("v%0d_mem_rd", i), ex_mem_rd, vecs[i].e_mem_rd);
    end

    // Load-use: load to r2, then a consumer of rt=r2
    id_valid = 1; imm_sel = 2'd3; zext = 0; bsrc_imm = 0; rd_sel = 2'd0;
    instr = 16'h0008; reg_wr = 1; mem_rd = 1; uses_rs = 0; uses_rt = 0;
    step();
    chk("lu_load_mem_rd", ex_mem_rd, 1'b1);
    chk("lu_load_rd", ex_rd, 3'd2);
    instr = 16'h0040; mem_rd = 0; uses_rt = 1;
    #1;
    chk("lu_stall", stall_out, 1'b1);
    step();
    chk("lu_bubble_valid", ex_valid, 1'b0);
    chk("lu_stall_gone", stall_out, 1'b0);
    step();
    chk("lu_issue_valid", ex_valid, 1'b1);
    chk("lu_issue_rt", ex_rt_data, 16'h0211);

    // Hazard together with flush: no stall, bubble
    instr = 16'h0008; mem_rd = 1; uses_rt = 0;
    step();
    instr = 16'h0040; mem_rd = 0; uses_rt = 1; flush = 1;
    #1;
    chk("flush_hz_stall", stall_out, 1'b0);
    step();
    chk("flush_hz_valid", ex_valid, 1'b0);
    chk("flush_hz_mem_rd", ex_mem_rd, 1'b0);
    flush = 0; uses_rt = 0;

    // Hold for 3 cycles with new inputs presented
    wb_en = 1; wb_reg = 3'd5; wb_data = 16'h1234; instr = 16'h0500; pc_next = 16'h0042;
    step();
    chk("hold_setup_a", ex_a, 16'h1234);
    wb_en = 0; hold = 1; instr = 16'h0100; pc_next = 16'h0099; id_valid = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("hold%0d_valid", i), ex_valid, 1'b1);
      chk($sformatf("hold%0d_a", i), ex_a, 16'h1234);
      chk($sformatf("hold%0d_pc", i), ex_pc_next, 16'h0042);
    end
    flush = 1;
    step();
    chk("hold_flush_valid", ex_valid, 1'b0);
    hold = 0; flush = 0;

    // Asynchronous reset mid-cycle, and no write on an edge with rst=1
    id_valid = 1; instr = 16'h0200; reg_wr = 1;
    step();
    chk("mid_pre_valid", ex_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_async_valid", ex_valid, 1'b0);
    chk("mid_async_a", ex_a, 16'h0);
    chk("mid_async_reg_wr", ex_reg_wr, 1'b0);
    wb_en = 1; wb_reg = 3'd6; wb_data = 16'hDEAD;
    step();
    wb_en = 0; rst = 1'b0;
    instr = 16'h0600;
    step();
    chk("mid_r6_no_write", ex_a, 16'h0);
    instr = 16'h0200;
    step();
    chk("mid_r2_cleared", ex_a, 16'h0);

    // Wide build
    id_valid = 0;
    wb_en_w = 1; wb_reg_w = 4'd15; wb_data_w = 32'h8000_0001;
    step();
    wb_en_w = 0; id_valid_w = 1; instr_w = 16'h0700; imm_sel_w = 2'd2; rd_sel_w = 2'd3;
    step();
    chk("w_r7_not_r15", ex_a_w, 32'h0);
    chk("w_link_rd", ex_rd_w, 4'd15);
    wb_en_w = 1; wb_reg_w = 4'd7; wb_data_w = 32'h8000_0001; instr_w = 16'h0400;
    step();
    chk("w_imm11", ex_imm_w, 32'hFFFF_FC00);
    instr_w = 16'h0700;
    step();
    chk("w_bypass_r7", ex_a_w, 32'h8000_0001);
    wb_en_w = 0;
    step();
    chk("w_file_r7", ex_a_w, 32'h8000_0001);
    chk("w_valid", ex_valid_w, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
